// File: rtl/hqm_aw_sync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hqm_aw_sync_filter                                               |
// | Purpose : Multi-bit level synchronizer (STAGES-deep chain) followed by a   |
// |           per-bit debounce filter with one-cycle rise/fall pulse outputs.  |
// | Option  : HQM_AW_SYNC_FILTER_STICKY_EN adds sticky_clr / sticky_chg, a     |
// |           per-bit sticky change flag set by rise|fall, cleared by clr.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hqm_aw_sync_filter #(
   parameter int               WIDTH   = 1,
   parameter int               STAGES  = 2,
   parameter int               FILTER  = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data,
`ifdef HQM_AW_SYNC_FILTER_STICKY_EN
   input  logic [WIDTH-1:0] sticky_clr,
   output logic [WIDTH-1:0] sticky_chg,
`endif
   output logic [WIDTH-1:0] data_sync,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   // Counter only has to reach FILTER-1, so $clog2(FILTER) bits suffice (min 1).
   localparam int            c_cw      = (FILTER > 1) ? $clog2(FILTER) : 1;
   localparam logic [c_cw-1:0] c_cnt_max = c_cw'(FILTER - 1);

   if ((STAGES < 2) || (STAGES > 4)) begin : g_bad_stages
      $error("hqm_aw_sync_filter: STAGES must be in 2..4");
   end
   if (FILTER < 1) begin : g_bad_filter
      $error("hqm_aw_sync_filter: FILTER must be >= 1");
   end

   // Every flop in this chain is a synchronizer stage (doublesync-class cell).
   logic [WIDTH-1:0] r_sync [STAGES];
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic [c_cw-1:0]  r_cnt  [WIDTH];
   logic [c_cw-1:0]  w_cnt_nxt [WIDTH];
   logic [WIDTH-1:0] w_out_nxt;

   // Sync chain: stage 0 captures the raw input, each later stage follows the previous one.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) r_sync[k] <= RST_VAL;
      end else begin
         r_sync[0] <= data;
         for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
   end

   assign data_sync = r_sync[STAGES-1];

   // Debounce: a bit flips only after FILTER consecutive mismatching cycles; any match restarts.
   always_comb begin
      w_out_nxt = r_out;
      for (int i = 0; i < WIDTH; i++) begin
         w_cnt_nxt[i] = '0;
         if (data_sync[i] != r_out[i]) begin
            if (r_cnt[i] == c_cnt_max) begin
               w_out_nxt[i] = data_sync[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Filtered level, counters and edge pulses registered together so pulses align with data_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out  <= RST_VAL;
         r_rise <= '0;
         r_fall <= '0;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         r_out  <= w_out_nxt;
         r_rise <= w_out_nxt & ~r_out;
         r_fall <= ~w_out_nxt & r_out;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end

   assign data_out = r_out;
   assign rise     = r_rise;
   assign fall     = r_fall;

`ifdef HQM_AW_SYNC_FILTER_STICKY_EN
   logic [WIDTH-1:0] r_sticky;

   // Sticky change flag: a pulse sets it and takes priority over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sticky <= '0;
      end else begin
         r_sticky <= r_rise | r_fall | (r_sticky & ~sticky_clr);
      end
   end

   assign sticky_chg = r_sticky;
`endif

endmodule
`default_nettype wire
